// File: rtl/adder_chk_pkg.sv
// ---------------------------------------------------------------------------
// adder_chk_pkg
// Shared definitions for the adder response checker:
//   - state_e  : run-control states of the checker
//   - vec_w()  : width of a captured {a, b, cin, sum, cout} record
//   - res_w()  : width of the golden {cout, sum} result
//   - sat_inc(): increment that sticks at the all-ones value of a counter
// ---------------------------------------------------------------------------
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // {a, b, cin, sum, cout}
    function automatic int vec_w(input int width);
        return 3 * width + 2;
    endfunction

    // {cout, sum}
    function automatic int res_w(input int width);
        return width + 1;
    endfunction

    // Counter increment saturating at 2^w - 1; counters up to 32 bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] maxv;
        maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= maxv) ? maxv : (v + 32'd1);
    endfunction

endpackage

// File: rtl/adder_golden.sv
// ---------------------------------------------------------------------------
// adder_golden
// Combinational reference adder: {cout_o, sum_o} = a_i + b_i + cin_i,
// evaluated at WIDTH+1 bits with zero-extended operands.
// Ports:
//   a_i, b_i  in  WIDTH  operands
//   cin_i     in  1      carry-in
//   sum_o     out WIDTH  expected sum
//   cout_o    out 1      expected carry-out
// ---------------------------------------------------------------------------
module adder_golden
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int RES_W = res_w(WIDTH);

    logic [RES_W-1:0] res;

    always_comb begin
        res = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    end

    assign sum_o  = res[WIDTH-1:0];
    assign cout_o = res[WIDTH];

endmodule

// File: rtl/adder_vec_checker.sv
// ---------------------------------------------------------------------------
// adder_vec_checker
// Consumes applied adder vectors together with the DUT's observed results,
// recomputes the golden result and keeps pass/fail statistics plus a copy of
// the first failing vector.
//
// Pipeline: stage 1 registers an accepted beat; stage 2 compares the stage-1
// register against adder_golden and updates the statistics on the next edge.
//
// Ports:
//   clk, rst_n       clock / asynchronous active-low reset
//   start            one-cycle pulse: clear statistics, arm a run (IDLE/DONE)
//   in_valid/ready   beat handshake, ready only while running
//   in_a, in_b       operands applied to the adder DUT
//   in_cin           carry-in applied to the adder DUT
//   in_sum, in_cout  result observed from the adder DUT
//   in_last          final beat of the run
//   done, pass       run finished / finished with no mismatch
//   vec_cnt          vectors checked (saturating)
//   fail_cnt         mismatching vectors (saturating)
//   fail_seen        at least one mismatch this run
//   first_fail_idx   0-based index of the first mismatch
//   first_fail_vec   {a, b, cin, sum, cout} of the first mismatch
// ---------------------------------------------------------------------------
module adder_vec_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    input  logic [WIDTH-1:0]   in_sum,
    input  logic               in_cout,
    input  logic               in_last,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   vec_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               fail_seen,
    output logic [CNT_W-1:0]   first_fail_idx,
    output logic [3*WIDTH+1:0] first_fail_vec
);

    localparam int VEC_W = vec_w(WIDTH);

    state_e state_q, state_d;

    logic accept;
    logic clear;

    assign accept = in_valid & in_ready;
    // start only arms a run from IDLE or DONE; in RUN/DRAIN it is ignored
    assign clear  = start & ((state_q == IDLE) | (state_q == DONE));

    // ---------------- stage 1: register accepted beat ----------------
    logic             vld_p1_q;
    logic [WIDTH-1:0] a_p1_q, b_p1_q, sum_p1_q;
    logic             cin_p1_q, cout_p1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            a_p1_q    <= '0;
            b_p1_q    <= '0;
            cin_p1_q  <= 1'b0;
            sum_p1_q  <= '0;
            cout_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= accept;
            if (accept) begin
                a_p1_q    <= in_a;
                b_p1_q    <= in_b;
                cin_p1_q  <= in_cin;
                sum_p1_q  <= in_sum;
                cout_p1_q <= in_cout;
            end
        end
    end

    // ---------------- stage 2: golden compare, statistics ----------------
    logic [WIDTH-1:0] exp_sum_p2;
    logic             exp_cout_p2;
    logic             mismatch_p2;

    adder_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .a_i    (a_p1_q),
        .b_i    (b_p1_q),
        .cin_i  (cin_p1_q),
        .sum_o  (exp_sum_p2),
        .cout_o (exp_cout_p2)
    );

    assign mismatch_p2 = vld_p1_q & ((exp_sum_p2 != sum_p1_q) | (exp_cout_p2 != cout_p1_q));

    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             fail_seen_q, fail_seen_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [VEC_W-1:0] ff_vec_q, ff_vec_d;

    always_comb begin
        vec_cnt_d   = vec_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        fail_seen_d = fail_seen_q;
        ff_idx_d    = ff_idx_q;
        ff_vec_d    = ff_vec_q;
        if (clear) begin
            // stage 1 is always empty in IDLE/DONE, so nothing is lost here
            vec_cnt_d   = '0;
            fail_cnt_d  = '0;
            fail_seen_d = 1'b0;
            ff_idx_d    = '0;
            ff_vec_d    = '0;
        end else if (vld_p1_q) begin
            vec_cnt_d = CNT_W'(sat_inc(32'(vec_cnt_q), CNT_W));
            if (mismatch_p2) begin
                fail_cnt_d = CNT_W'(sat_inc(32'(fail_cnt_q), CNT_W));
                if (!fail_seen_q) begin
                    fail_seen_d = 1'b1;
                    ff_idx_d    = vec_cnt_q;
                    ff_vec_d    = {a_p1_q, b_p1_q, cin_p1_q, sum_p1_q, cout_p1_q};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt_q   <= '0;
            fail_cnt_q  <= '0;
            fail_seen_q <= 1'b0;
            ff_idx_q    <= '0;
            ff_vec_q    <= '0;
        end else begin
            vec_cnt_q   <= vec_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_seen_q <= fail_seen_d;
            ff_idx_q    <= ff_idx_d;
            ff_vec_q    <= ff_vec_d;
        end
    end

    // ---------------- run control ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && in_last) state_d = DRAIN;
            // stage 2 retires at the same edge stage 1 empties, so an empty
            // stage 1 means the statistics are already final
            DRAIN:   if (!vld_p1_q) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_ready       = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = done & (fail_cnt_q == '0);
    assign vec_cnt        = vec_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign fail_seen      = fail_seen_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_vec = ff_vec_q;

endmodule

// File: tb/tb_adder_vec_checker.sv
module tb_adder_vec_checker;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
    } beat_t;

    typedef struct packed {
        logic a;
        logic b;
        logic cin;
        logic exp_sum;
        logic exp_cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 bus, shared by u1 (CNT_W=16) and u3 (CNT_W=3)
    logic start1 = 0, vld1 = 0, a1 = 0, b1 = 0, cin1 = 0, sum1 = 0, cout1 = 0, last1 = 0;
    logic rdy1, done1, pass1, fs1;
    logic [15:0] vc1, fc1, ffi1;
    logic [4:0]  ffv1;
    logic rdy3, done3, pass3, fs3;
    logic [2:0]  vc3, fc3, ffi3;
    logic [4:0]  ffv3;

    // WIDTH=4 bus
    logic start4 = 0, vld4 = 0, cin4 = 0, cout4 = 0, last4 = 0;
    logic [3:0] a4 = 0, b4 = 0, sum4 = 0;
    logic rdy4, done4, pass4, fs4;
    logic [15:0] vc4, fc4, ffi4;
    logic [13:0] ffv4;

    adder_vec_checker #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(vld1), .in_ready(rdy1),
        .in_a(a1), .in_b(b1), .in_cin(cin1), .in_sum(sum1), .in_cout(cout1), .in_last(last1),
        .done(done1), .pass(pass1), .vec_cnt(vc1), .fail_cnt(fc1), .fail_seen(fs1),
        .first_fail_idx(ffi1), .first_fail_vec(ffv1));

    adder_vec_checker #(.WIDTH(1), .CNT_W(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(vld1), .in_ready(rdy3),
        .in_a(a1), .in_b(b1), .in_cin(cin1), .in_sum(sum1), .in_cout(cout1), .in_last(last1),
        .done(done3), .pass(pass3), .vec_cnt(vc3), .fail_cnt(fc3), .fail_seen(fs3),
        .first_fail_idx(ffi3), .first_fail_vec(ffv3));

    adder_vec_checker #(.WIDTH(4), .CNT_W(16)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(vld4), .in_ready(rdy4),
        .in_a(a4), .in_b(b4), .in_cin(cin4), .in_sum(sum4), .in_cout(cout4), .in_last(last4),
        .done(done4), .pass(pass4), .vec_cnt(vc4), .fail_cnt(fc4), .fail_seen(fs4),
        .first_fail_idx(ffi4), .first_fail_vec(ffv4));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit w4, input logic v, input beat_t bt, input logic l);
        if (w4) begin
            vld4 = v; a4 = bt.a; b4 = bt.b; cin4 = bt.cin; sum4 = bt.sum; cout4 = bt.cout; last4 = l;
        end else begin
            vld1 = v; a1 = bt.a[0]; b1 = bt.b[0]; cin1 = bt.cin; sum1 = bt.sum[0]; cout1 = bt.cout; last1 = l;
        end
    endtask

    task automatic set_start(input bit w4, input logic v);
        if (w4) start4 = v;
        else    start1 = v;
    endtask

    function automatic logic get_rdy(input bit w4);
        return w4 ? rdy4 : rdy1;
    endfunction

    function automatic logic get_done(input bit w4);
        return w4 ? done4 : done1;
    endfunction

    // Reference: statistics implied by a list of accepted beats.
    task automatic model(input bit w4, input beat_t bq[$], input int cbits,
                         output longint vc, output longint fc, output longint fi,
                         output longint fv, output bit fs);
        int w;
        longint cap, full, es, ec;
        w = w4 ? 4 : 1;
        cap = (longint'(1) << cbits) - 1;
        vc = 0; fc = 0; fi = 0; fv = 0; fs = 0;
        foreach (bq[i]) begin
            full = longint'(bq[i].a) + longint'(bq[i].b) + longint'(bq[i].cin);
            es = full % (longint'(1) << w);
            ec = full >> w;
            if (es != longint'(bq[i].sum) || ec != longint'(bq[i].cout)) begin
                if (!fs) begin
                    fs = 1;
                    fi = vc;
                    fv = longint'(bq[i].a);
                    fv = (fv << w) | longint'(bq[i].b);
                    fv = (fv << 1) | longint'(bq[i].cin);
                    fv = (fv << w) | longint'(bq[i].sum);
                    fv = (fv << 1) | longint'(bq[i].cout);
                end
                fc = (fc + 1 > cap) ? cap : fc + 1;
            end
            vc = (vc + 1 > cap) ? cap : vc + 1;
        end
    endtask

    task automatic check_stats(input bit w4, input beat_t bq[$]);
        longint vc, fc, fi, fv;
        bit fs;
        if (w4) begin
            model(1'b1, bq, 16, vc, fc, fi, fv, fs);
            chk("u4_vec_cnt", vc4, vc);
            chk("u4_fail_cnt", fc4, fc);
            chk("u4_fail_seen", fs4, fs);
            chk("u4_first_idx", ffi4, fi);
            chk("u4_first_vec", ffv4, fv);
            chk("u4_pass", pass4, fc == 0);
        end else begin
            model(1'b0, bq, 16, vc, fc, fi, fv, fs);
            chk("u1_vec_cnt", vc1, vc);
            chk("u1_fail_cnt", fc1, fc);
            chk("u1_fail_seen", fs1, fs);
            chk("u1_first_idx", ffi1, fi);
            chk("u1_first_vec", ffv1, fv);
            chk("u1_pass", pass1, fc == 0);
            model(1'b0, bq, 3, vc, fc, fi, fv, fs);
            chk("u3_vec_cnt", vc3, vc);
            chk("u3_fail_cnt", fc3, fc);
            chk("u3_first_vec", ffv3, fv);
            chk("u3_done", done3, 1);
        end
    endtask

    // One run: start (with an unacceptable beat on the bus), beats with
    // optional valid gaps, optional start pulse mid-run, then done latency.
    task automatic run(input bit w4, input beat_t bq[$], input int gap_pct, input int start_at);
        beat_t junk;
        int i;
        junk = '{a: 4'h1, b: 4'h1, cin: 1'b1, sum: 4'h0, cout: 1'b0};
        chk("ready_before_start", get_rdy(w4), 0);
        drive(w4, 1'b1, junk, 1'b1);
        set_start(w4, 1'b1);
        @(posedge clk); #1;
        set_start(w4, 1'b0);
        chk("ready_in_run", get_rdy(w4), 1);
        i = 0;
        while (i < bq.size()) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                drive(w4, 1'b0, junk, 1'b1);
            end else begin
                drive(w4, 1'b1, bq[i], i == bq.size() - 1);
                set_start(w4, i == start_at);
                i++;
            end
            @(posedge clk); #1;
            set_start(w4, 1'b0);
        end
        drive(w4, 1'b1, junk, 1'b1);
        chk("done_after_last", get_done(w4), 0);
        chk("ready_in_drain", get_rdy(w4), 0);
        @(posedge clk); #1;
        chk("done_last_plus1", get_done(w4), 0);
        @(posedge clk); #1;
        drive(w4, 1'b0, junk, 1'b0);
        chk("done_last_plus2", get_done(w4), 1);
        chk("ready_in_done", get_rdy(w4), 0);
        check_stats(w4, bq);
    endtask

    function automatic beat_t rand_beat(input bit w4);
        beat_t bt;
        int full;
        int w;
        w = w4 ? 4 : 1;
        bt.a = 4'($urandom_range((1 << w) - 1));
        bt.b = 4'($urandom_range((1 << w) - 1));
        bt.cin = 1'($urandom_range(1));
        full = int'(bt.a) + int'(bt.b) + int'(bt.cin);
        bt.sum = 4'(full % (1 << w));
        bt.cout = 1'(full >> w);
        if ($urandom_range(3) == 0) begin
            if ($urandom_range(w) == 0) bt.cout = ~bt.cout;
            else bt.sum[$urandom_range(w - 1)] = ~bt.sum[$urandom_range(w - 1)];
        end
        return bt;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    vec_t  tbl[8];
    beat_t good[$], bad[$], rq[$], q4[$];
    beat_t bt;

    initial begin
        tbl = '{5'b000_00, 5'b001_10, 5'b010_10, 5'b011_01,
                5'b100_10, 5'b101_01, 5'b110_01, 5'b111_11};
        foreach (tbl[i]) begin
            bt = '{a: {3'b0, tbl[i].a}, b: {3'b0, tbl[i].b}, cin: tbl[i].cin,
                   sum: {3'b0, tbl[i].exp_sum}, cout: tbl[i].exp_cout};
            good.push_back(bt);
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_vec_cnt", vc1, 0);
        chk("rst_fail_cnt", fc1, 0);
        chk("rst_fail_seen", fs1, 0);
        chk("rst_first_idx", ffi1, 0);
        chk("rst_first_vec", ffv1, 0);
        chk("rst_w4_vec", ffv4, 0);
        rst_n = 1'b1;

        // Valid held before any start is ignored
        drive(1'b0, 1'b1, good[7], 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_start_ready", rdy1, 0);
        chk("pre_start_vec_cnt", vc1, 0);
        chk("pre_start_done", done1, 0);

        // All 8 correct vectors back-to-back
        run(1'b0, good, 0, -1);
        chk("t1_vec_cnt", vc1, 8);
        chk("t1_fail_cnt", fc1, 0);
        chk("t1_pass", pass1, 1);
        chk("t1_u3_sat", vc3, 7);

        // Index 3 reports sum=1,cout=1; index 6 sum flipped; start in RUN ignored
        bad = good;
        bad[3].sum = 4'h1; bad[3].cout = 1'b1;
        bad[6].sum = 4'h1;
        run(1'b0, bad, 0, 5);
        chk("t2_fail_cnt", fc1, 2);
        chk("t2_first_idx", ffi1, 3);
        chk("t2_first_vec", ffv1, 5'b01111);
        chk("t2_pass", pass1, 0);

        // Statistics hold in DONE
        repeat (4) @(posedge clk);
        #1;
        chk("t2_hold_fail_cnt", fc1, 2);
        chk("t2_hold_done", done1, 1);

        // WIDTH=4 carry vector
        q4.delete();
        q4.push_back('{a: 4'hF, b: 4'h1, cin: 1'b1, sum: 4'h1, cout: 1'b1});
        run(1'b1, q4, 0, -1);
        chk("w4_ok_fail_cnt", fc4, 0);
        chk("w4_ok_pass", pass4, 1);
        q4[0].cout = 1'b0;
        run(1'b1, q4, 0, -1);
        chk("w4_bad_fail_cnt", fc4, 1);
        chk("w4_bad_first_vec", ffv4, {4'hF, 4'h1, 1'b1, 4'h1, 1'b0});

        // Asynchronous reset mid-RUN after 3 beats
        rq = good;
        rq[1].sum = 4'h0;
        drive(1'b0, 1'b0, good[0], 1'b0);
        set_start(1'b0, 1'b1);
        @(posedge clk); #1;
        set_start(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, rq[k], 1'b0);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, good[0], 1'b0);
        @(posedge clk); #1;
        chk("mid_pre_vec_cnt", vc1, 3);
        chk("mid_pre_fail_seen", fs1, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec_cnt", vc1, 0);
        chk("mid_rst_fail_cnt", fc1, 0);
        chk("mid_rst_fail_seen", fs1, 0);
        chk("mid_rst_first_vec", ffv1, 0);
        chk("mid_rst_ready", rdy1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(1'b0, good, 0, -1);
        chk("post_rst_vec_cnt", vc1, 8);

        // Randomized runs against the reference model
        for (int r = 0; r < 8; r++) begin
            int n;
            bit w4;
            w4 = r[0];
            n = $urandom_range(3, 40);
            rq.delete();
            for (int k = 0; k < n; k++) rq.push_back(rand_beat(w4));
            run(w4, rq, 30, $urandom_range(0, n + 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_vec_checker.md
# adder_vec_checker

Hardware response checker for the adder verification flow: consumes a stream of applied adder vectors and the DUT's observed results {a, b, cin, sum, cout}, recomputes the golden result, and keeps pass/fail statistics plus a record of the first failing vector. It is the consuming end of the vector/result stream that the adder stimulus side produces. It sits beside the adder DUT and lets long regressions run without file-based post-processing.

## Interface
Parameters:
- WIDTH, 1, operand width of the adder under check
- CNT_W, 16, width of vector/fail counters and the failing-index register

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; clears statistics and arms a run
- in_valid  in  1  vector beat valid
- in_ready  out  1  checker can accept a beat
- in_a, in_b  in  WIDTH  operands applied to DUT
- in_cin  in  1  carry-in applied to DUT
- in_sum  in  WIDTH  DUT sum observed
- in_cout  in  1  DUT carry-out observed
- in_last  in  1  marks final beat of the run
- done  out  1  run complete, statistics final
- pass  out  1  done and fail_cnt == 0
- vec_cnt  out  CNT_W  vectors checked
- fail_cnt  out  CNT_W  mismatching vectors
- fail_seen  out  1  at least one mismatch this run
- first_fail_idx  out  CNT_W  0-based index of first mismatch
- first_fail_vec  out  3*WIDTH+2  {a, b, cin, sum, cout} of first mismatch

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. start -> RUN, clear all statistics.
- RUN: in_ready=1. Beat accepted when in_valid & in_ready. Accepted beat with in_last=1 -> DRAIN.
- DRAIN: in_ready=0; wait until both pipeline stages empty -> DONE.
- DONE: done=1, in_ready=0. start -> RUN with statistics cleared. start in RUN or DRAIN ignored.
- Golden: {exp_cout, exp_sum} = a + b + cin at WIDTH+1 bits, zero-extended. Mismatch if exp_sum != in_sum or exp_cout != in_cout.
- Per checked beat: vec_cnt += 1. On mismatch fail_cnt += 1. Both saturate at 2^CNT_W-1, no wrap.
- First mismatch only: capture first_fail_idx = vec_cnt value before increment, first_fail_vec = the beat fields, set fail_seen. Later mismatches do not overwrite.
- Beats arriving while in_ready=0 are ignored and not counted.
- Reset mid-operation: everything returns to reset values. In-flight beats are discarded.

## Timing
- Reset values: state IDLE, in_ready=0, done=0, pass=0, all counters, fail_seen, first_fail_idx and first_fail_vec = 0. Pipeline valid bits = 0.
- Stage 1: accepted beat registered at edge k.
- Stage 2: golden compare on the stage-1 register. Counters and first-fail fields update at edge k+1 and are visible from the cycle after edge k+1.
- Throughput: one beat per cycle in RUN, no bubbles.
- Last beat accepted at edge k: state=DRAIN after k. done=1 visible after edge k+2, with final statistics already stable.
- start in the same cycle as in_valid in IDLE/DONE: the beat is not accepted, because in_ready was 0.
- Statistics hold their values in DONE until the next start or reset.

## Structure
- Package adder_chk_pkg: state enum (IDLE/RUN/DRAIN/DONE), vector record field widths derived from WIDTH, saturating-increment function.
- Sub-module adder_golden: combinational WIDTH-bit reference adder, outputs {exp_cout, exp_sum}. Instantiated once in stage 2.

## Test plan
- WIDTH=1, all 8 vectors {a,b,cin}=000..111 with correct sum/cout, last on the 8th -> vec_cnt=8, fail_cnt=0, pass=1, done 2 cycles after the last accept.
- Same 8 vectors, but index 3 (a=0, b=1, cin=1) reports sum=1, cout=1, and index 6 is also corrupted -> fail_cnt=2, first_fail_idx=3, first_fail_vec=5'b01111, pass=0.
- in_valid=1 held before any start -> in_ready=0, vec_cnt stays 0. After start, one beat per cycle is accepted back-to-back.
- CNT_W=3, 10 correct vectors -> vec_cnt saturates at 7, fail_cnt=0.
- WIDTH=4: a=4'hF, b=4'h1, cin=1 with sum=4'h1, cout=1 -> no fail. The same vector with cout=0 -> fail_cnt=1.
- rst_n asserted low mid-RUN after 3 beats -> all outputs return to 0 asynchronously, state IDLE. A new start then counts from 0.
